tmds_channel_decoder: RTL and testbench
=======================================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 LOCK_COUNT, 8, consecutive valid control tokens needed to declare word lock (2..255).
REQ-002 SLIP_INTERVAL, 1024, valid symbols allowed in SEARCH before a bitslip request (16..65535).
REQ-003 LOSS_TIMEOUT, 8192, valid symbols without a control token before lock is dropped (16..65535).
REQ-004 clk_pixel  in  1  pixel clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tmds_symbol  in  10  deserialized TMDS symbol, q[9:0], bit 0 first on the wire.
REQ-007 symbol_valid  in  1  tmds_symbol valid this cycle.
REQ-008 bitslip  out  1  single-cycle request to the deserializer to shift the word boundary by one bit.
REQ-009 locked  out  1  word alignment established.
REQ-010 out_valid  out  1  decoded outputs valid this cycle.
REQ-011 video_data  out  8  TMDS video decode of the symbol.
REQ-012 ctrl  out  2  {c1,c0} of a matched control token.
REQ-013 is_ctrl  out  1  symbol matched a control token.
REQ-014 terc4_data  out  4  TERC4 decode of the symbol.
REQ-015 is_terc4  out  1  symbol matched a TERC4 code.

Function
REQ-016 The decode path SHALL be registered with 1-cycle latency: outputs reflect the symbol sampled on the previous edge with symbol_valid=1, and out_valid SHALL equal the previous cycle's symbol_valid.
REQ-017 When symbol_valid=0, the decode outputs other than out_valid SHALL hold, and all counters SHALL hold.
REQ-018 Video decode: d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]); this is computed for every symbol.
REQ-019 Control tokens: 0x354->00, 0x0AB->01, 0x154->10, 0x2AB->11; on a match is_ctrl=1, otherwise is_ctrl=0 and ctrl=00.
REQ-020 TERC4 codes 0..15 map to 0x29C, 0x263, 0x2E4, 0x2E2, 0x171, 0x11E, 0x18E, 0x13C, 0x2CC, 0x139, 0x19C, 0x2C6, 0x28E, 0x271, 0x163, 0x2C3; on a match is_terc4=1, otherwise is_terc4=0 and terc4_data=0.
REQ-021 The FSM SHALL have two states, SEARCH and LOCKED; SEARCH is the reset state.
REQ-022 In SEARCH, run_cnt SHALL increment on each valid control token and clear on each valid non-control symbol; reaching LOCK_COUNT SHALL move the FSM to LOCKED, with locked=1 from the next cycle.
REQ-023 In SEARCH, slip_cnt SHALL count valid symbols; on reaching SLIP_INTERVAL without locking, the block SHALL pulse bitslip for exactly 1 cycle and clear both slip_cnt and run_cnt.
REQ-024 If the lock condition and the slip condition occur on the same symbol, lock SHALL win and no bitslip SHALL be issued.
REQ-025 In LOCKED, idle_cnt SHALL clear on each valid control token and increment on each other valid symbol; reaching LOSS_TIMEOUT SHALL move the FSM to SEARCH, set locked=0 on the next cycle, and clear all counters.
REQ-026 bitslip SHALL never assert in LOCKED, and consecutive bitslip pulses SHALL be at least SLIP_INTERVAL valid symbols apart.
REQ-027 Counters SHALL be sized to hold their parameter and SHALL saturate rather than wrap.
REQ-028 The decode outputs SHALL be independent of lock state.

Reset
REQ-029 On reset_n=0, the block SHALL immediately set the FSM to SEARCH, clear all counters, and drive bitslip, locked, out_valid, video_data, ctrl, is_ctrl, terc4_data and is_terc4 to 0.
REQ-030 Reset asserted mid-operation SHALL abort any lock or slip in progress, and release SHALL begin a fresh search.

Verification
REQ-031 Symbols 0x100, 0x1FF, 0x2FF -> video_data 0x00, 0x01, 0xFE one cycle later, with is_ctrl=0.
REQ-032 All 4 control tokens and all 16 TERC4 codes -> the correct ctrl/terc4_data with the matching flag set; 0x100 -> both flags 0.
REQ-033 LOCK_COUNT=8: 7 consecutive 0x354 followed by 0x100 -> no lock; then 8 consecutive 0x354 -> locked=1 on the cycle after the 8th output.
REQ-034 SLIP_INTERVAL=16 with only 0x100 input -> bitslip pulses every 16 valid symbols; gaps in symbol_valid stretch the interval.
REQ-035 LOSS_TIMEOUT=32 after lock with only video symbols -> locked drops after 32 symbols; a control token at symbol 31 restarts the count.
REQ-036 reset_n pulsed low while LOCKED -> locked=0 immediately, and relocking requires a full LOCK_COUNT run.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_decoder
//
// One TMDS channel receive back-end: decodes each deserialized 10-bit symbol
// as video data, a control token and a TERC4 code (all three in parallel,
// registered, 1-cycle latency), and runs a word-alignment tracker that asks
// the deserializer to bitslip until a run of control tokens is seen.
//
// Ports
//   clk_pixel     in   pixel clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   tmds_symbol   in   [9:0] deserialized symbol q[9:0], bit 0 first on wire
//   symbol_valid  in   tmds_symbol is valid this cycle
//   bitslip       out  one-cycle request to shift the word boundary by 1 bit
//   locked        out  word alignment established
//   out_valid     out  decode outputs valid this cycle
//   video_data    out  [7:0] TMDS video decode
//   ctrl          out  [1:0] {c1,c0} of a matched control token
//   is_ctrl       out  symbol matched a control token
//   terc4_data    out  [3:0] TERC4 decode
//   is_terc4      out  symbol matched a TERC4 code
// ---------------------------------------------------------------------------
module tmds_channel_decoder #(
    parameter int LOCK_COUNT    = 8,     // 2..255
    parameter int SLIP_INTERVAL = 1024,  // 16..65535
    parameter int LOSS_TIMEOUT  = 8192   // 16..65535
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] tmds_symbol,
    input  logic       symbol_valid,
    output logic       bitslip,
    output logic       locked,
    output logic       out_valid,
    output logic [7:0] video_data,
    output logic [1:0] ctrl,
    output logic       is_ctrl,
    output logic [3:0] terc4_data,
    output logic       is_terc4
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int SLIP_W = $clog2(SLIP_INTERVAL + 1);
    localparam int IDLE_W = $clog2(LOSS_TIMEOUT + 1);

    typedef struct packed {
        logic [7:0] video;
        logic [1:0] ctrl;
        logic       is_ctrl;
        logic [3:0] terc4;
        logic       is_terc4;
    } dec_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Combinational decode of the incoming symbol
    // -----------------------------------------------------------------------
    dec_t       dec;
    logic [7:0] d;

    always_comb begin
        dec = '0;
        // q[9] flags an inverted data byte, q[8] selects XOR vs XNOR chain.
        d = tmds_symbol[9] ? ~tmds_symbol[7:0] : tmds_symbol[7:0];
        dec.video[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec.video[i] = tmds_symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end

        case (tmds_symbol)
            10'h354: begin dec.is_ctrl = 1'b1; dec.ctrl = 2'b00; end
            10'h0AB: begin dec.is_ctrl = 1'b1; dec.ctrl = 2'b01; end
            10'h154: begin dec.is_ctrl = 1'b1; dec.ctrl = 2'b10; end
            10'h2AB: begin dec.is_ctrl = 1'b1; dec.ctrl = 2'b11; end
            default: ;
        endcase

        case (tmds_symbol)
            10'h29C: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd0;  end
            10'h263: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd1;  end
            10'h2E4: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd2;  end
            10'h2E2: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd3;  end
            10'h171: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd4;  end
            10'h11E: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd5;  end
            10'h18E: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd6;  end
            10'h13C: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd7;  end
            10'h2CC: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd8;  end
            10'h139: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd9;  end
            10'h19C: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd10; end
            10'h2C6: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd11; end
            10'h28E: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd12; end
            10'h271: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd13; end
            10'h163: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd14; end
            10'h2C3: begin dec.is_terc4 = 1'b1; dec.terc4 = 4'd15; end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Decode output register: loads only on valid symbols, otherwise holds
    // -----------------------------------------------------------------------
    dec_t dec_q;
    logic vld_q;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            dec_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= symbol_valid;
            if (symbol_valid) dec_q <= dec;
        end
    end

    assign out_valid  = vld_q;
    assign video_data = dec_q.video;
    assign ctrl       = dec_q.ctrl;
    assign is_ctrl    = dec_q.is_ctrl;
    assign terc4_data = dec_q.terc4;
    assign is_terc4   = dec_q.is_terc4;

    // -----------------------------------------------------------------------
    // Word-alignment FSM
    // -----------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [RUN_W-1:0]    run_cnt, run_nxt;
    logic [SLIP_W-1:0]   slip_cnt, slip_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic                slip_req;
    logic                lock_hit, slip_hit, loss_hit;

    // Terminal checks look at the count *before* this symbol, so the
    // N-th qualifying symbol is the one that fires.
    assign lock_hit = dec.is_ctrl && (run_cnt  >= RUN_W'(LOCK_COUNT - 1));
    assign slip_hit =                (slip_cnt >= SLIP_W'(SLIP_INTERVAL - 1));
    assign loss_hit = !dec.is_ctrl && (idle_cnt >= IDLE_W'(LOSS_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        slip_nxt  = slip_cnt;
        idle_nxt  = idle_cnt;
        slip_req  = 1'b0;

        if (symbol_valid) begin
            unique case (state)
                SEARCH: begin
                    if (lock_hit) begin
                        // Lock takes priority over a coincident slip.
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                        slip_nxt  = '0;
                        idle_nxt  = '0;
                    end else if (slip_hit) begin
                        slip_req = 1'b1;
                        run_nxt  = '0;
                        slip_nxt = '0;
                    end else begin
                        // Saturating increments; terminal values normally
                        // clear first, the limit guards against wrap.
                        if (dec.is_ctrl)
                            run_nxt = (run_cnt < RUN_W'(LOCK_COUNT))
                                      ? run_cnt + RUN_W'(1) : run_cnt;
                        else
                            run_nxt = '0;
                        slip_nxt = (slip_cnt < SLIP_W'(SLIP_INTERVAL))
                                   ? slip_cnt + SLIP_W'(1) : slip_cnt;
                    end
                end
                LOCKED: begin
                    if (dec.is_ctrl) begin
                        idle_nxt = '0;
                    end else if (loss_hit) begin
                        state_nxt = SEARCH;
                        run_nxt   = '0;
                        slip_nxt  = '0;
                        idle_nxt  = '0;
                    end else begin
                        idle_nxt = (idle_cnt < IDLE_W'(LOSS_TIMEOUT))
                                   ? idle_cnt + IDLE_W'(1) : idle_cnt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            slip_cnt <= '0;
            idle_cnt <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            slip_cnt <= slip_nxt;
            idle_cnt <= idle_nxt;
            bitslip  <= slip_req;
            // locked trails the state register by one cycle, so it rises
            // the cycle after the decoded lock-completing token appears.
            locked   <= (state == LOCKED);
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_decoder
//
// Bench for tmds_channel_decoder with LOCK_COUNT=8, SLIP_INTERVAL=16,
// LOSS_TIMEOUT=32. A behavioural model (integer counters, lookup tables)
// predicts every output every cycle; a constant vector table and a few
// directed sequences cover decode values, lock, slip, loss and reset.
// ---------------------------------------------------------------------------
module tb_tmds_channel_decoder;

    localparam int LOCK = 8;
    localparam int SLIP = 16;
    localparam int LOSS = 32;

    logic       clk_pixel;
    logic       reset_n;
    logic [9:0] tmds_symbol;
    logic       symbol_valid;
    logic       bitslip;
    logic       locked;
    logic       out_valid;
    logic [7:0] video_data;
    logic [1:0] ctrl;
    logic       is_ctrl;
    logic [3:0] terc4_data;
    logic       is_terc4;

    tmds_channel_decoder #(
        .LOCK_COUNT   (LOCK),
        .SLIP_INTERVAL(SLIP),
        .LOSS_TIMEOUT (LOSS)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .tmds_symbol (tmds_symbol),
        .symbol_valid(symbol_valid),
        .bitslip     (bitslip),
        .locked      (locked),
        .out_valid   (out_valid),
        .video_data  (video_data),
        .ctrl        (ctrl),
        .is_ctrl     (is_ctrl),
        .terc4_data  (terc4_data),
        .is_terc4    (is_terc4)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] ctrl_tab  [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc_tab  [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                   10'h171, 10'h11E, 10'h18E, 10'h13C,
                                   10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                   10'h28E, 10'h271, 10'h163, 10'h2C3};

    // ---------------- behavioural model ----------------
    logic       e_valid, e_locked, e_bitslip, e_isc, e_ist;
    logic [7:0] e_video;
    logic [1:0] e_ctrl;
    logic [3:0] e_terc;
    bit         m_lk;
    int         m_run, m_slip, m_idle;

    // Inverse of the TMDS transition-minimising stage, as whole-byte math.
    function automatic logic [7:0] ref_video(input logic [9:0] q);
        logic [7:0] dd, o;
        dd = q[9] ? ~q[7:0] : q[7:0];
        o  = dd ^ {dd[6:0], 1'b0};
        if (!q[8]) o = o ^ 8'hFE;
        return o;
    endfunction

    task automatic model_reset();
        m_lk = 0; m_run = 0; m_slip = 0; m_idle = 0;
        e_valid = 0; e_locked = 0; e_bitslip = 0; e_isc = 0; e_ist = 0;
        e_video = 0; e_ctrl = 0; e_terc = 0;
    endtask

    task automatic model_step(input logic [9:0] q, input logic v);
        bit c;
        e_locked  = m_lk;
        e_bitslip = 0;
        e_valid   = v;
        if (v) begin
            e_video = ref_video(q);
            e_isc = 0; e_ctrl = 0; e_ist = 0; e_terc = 0;
            for (int k = 0; k < 4; k++)
                if (ctrl_tab[k] == q) begin e_isc = 1; e_ctrl = 2'(k); end
            for (int k = 0; k < 16; k++)
                if (terc_tab[k] == q) begin e_ist = 1; e_terc = 4'(k); end
            c = e_isc;
            if (!m_lk) begin
                m_slip++;
                m_run = c ? m_run + 1 : 0;
                if (m_run >= LOCK) begin
                    m_lk = 1; m_run = 0; m_slip = 0; m_idle = 0;
                end else if (m_slip >= SLIP) begin
                    e_bitslip = 1; m_run = 0; m_slip = 0;
                end
            end else begin
                m_idle = c ? 0 : m_idle + 1;
                if (m_idle >= LOSS) begin
                    m_lk = 0; m_run = 0; m_slip = 0; m_idle = 0;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid",  32'(out_valid),  32'(e_valid));
        chk("video_data", 32'(video_data), 32'(e_video));
        chk("ctrl",       32'(ctrl),       32'(e_ctrl));
        chk("is_ctrl",    32'(is_ctrl),    32'(e_isc));
        chk("terc4_data", 32'(terc4_data), 32'(e_terc));
        chk("is_terc4",   32'(is_terc4),   32'(e_ist));
        chk("locked",     32'(locked),     32'(e_locked));
        chk("bitslip",    32'(bitslip),    32'(e_bitslip));
    endtask

    // Drive one symbol, let the edge take it, check just after the edge.
    task automatic cycle(input logic [9:0] sym, input logic v);
        tmds_symbol  = sym;
        symbol_valid = v;
        @(posedge clk_pixel);
        model_step(sym, v);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        symbol_valid = 1'b0;
        @(posedge clk_pixel);
        #1;
        check_all();
        #2;
        reset_n = 1'b1;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct packed {
        logic [9:0] sym;
        logic       chk_vid;
        logic [7:0] video;
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic       is_terc4;
        logic [3:0] terc4;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int nv, npulse, pos0, pos1, mode;
        logic [31:0] rv;
        logic [9:0]  s;
        logic        v;

        vecs[0] = '{10'h100, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0};
        vecs[1] = '{10'h1FF, 1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 4'd0};
        vecs[2] = '{10'h2FF, 1'b1, 8'hFE, 1'b0, 2'd0, 1'b0, 4'd0};
        vecs[3] = '{10'h354, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 4'd0};
        vecs[4] = '{10'h0AB, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 4'd0};
        vecs[5] = '{10'h154, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 4'd0};
        vecs[6] = '{10'h2AB, 1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 4'd0};
        vecs[7]  = '{10'h29C, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[8]  = '{10'h263, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd1};
        vecs[9]  = '{10'h2E4, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd2};
        vecs[10] = '{10'h2E2, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd3};
        vecs[11] = '{10'h171, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd4};
        vecs[12] = '{10'h11E, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd5};
        vecs[13] = '{10'h18E, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd6};
        vecs[14] = '{10'h13C, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd7};
        vecs[15] = '{10'h2CC, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd8};
        vecs[16] = '{10'h139, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd9};
        vecs[17] = '{10'h19C, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd10};
        vecs[18] = '{10'h2C6, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd11};
        vecs[19] = '{10'h28E, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd12};
        vecs[20] = '{10'h271, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd13};
        vecs[21] = '{10'h163, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd14};
        vecs[22] = '{10'h2C3, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'd15};

        // ---- power-on reset ----
        reset_n      = 1'b0;
        symbol_valid = 1'b0;
        tmds_symbol  = 10'h000;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk_pixel);
        #1;
        check_all();
        reset_n = 1'b1;

        // ---- lock: 7 tokens + video does not lock; then 8 tokens lock.
        // The 8th token is also the 16th valid symbol: lock beats slip.
        for (int i = 0; i < 7; i++) cycle(10'h354, 1'b1);
        cycle(10'h100, 1'b1);
        chk("no_lock_after_7", 32'(locked), 32'd0);
        for (int i = 0; i < 8; i++) cycle(10'h354, 1'b1);
        chk("lock_lag", 32'(locked), 32'd0);
        chk("lock_beats_slip", 32'(bitslip), 32'd0);
        cycle(10'h100, 1'b1);                       // idle symbol 1
        chk("locked_after_8", 32'(locked), 32'd1);

        // ---- loss timeout with restart at symbol 31 ----
        for (int i = 0; i < 29; i++) cycle(10'h100, 1'b1);   // symbols 2..30
        cycle(10'h0AB, 1'b1);                                 // symbol 31: token
        for (int i = 0; i < 31; i++) cycle(10'h1FF, 1'b1);
        chk("loss_restart", 32'(locked), 32'd1);
        cycle(10'h1FF, 1'b1);                                 // 32nd since token
        chk("loss_lag", 32'(locked), 32'd1);
        cycle(10'h1FF, 1'b1);
        chk("loss_drop", 32'(locked), 32'd0);

        // ---- bitslip cadence with gaps in symbol_valid ----
        do_reset();
        nv = 0; npulse = 0; pos0 = 0; pos1 = 0;
        for (int c = 0; c < 50; c++) begin
            if (c % 5 == 4) cycle(10'h354, 1'b0);   // invalid token must be ignored
            else begin
                cycle(10'h100, 1'b1);
                nv++;
            end
            if (bitslip) begin
                if (npulse == 0) pos0 = nv;
                else if (npulse == 1) pos1 = nv;
                npulse++;
            end
        end
        chk("slip_pulses", 32'(npulse), 32'd2);
        chk("slip_pos0", 32'(pos0), 32'd16);
        chk("slip_pos1", 32'(pos1), 32'd32);

        // ---- reset while locked: immediate drop, full relock needed ----
        do_reset();
        for (int i = 0; i < 8; i++) cycle(10'h154, 1'b1);
        cycle(10'h2AB, 1'b1);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_locked_now", 32'(locked), 32'd0);
        chk("reset_isctrl_now", 32'(is_ctrl), 32'd0);
        check_all();
        @(posedge clk_pixel);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) cycle(10'h354, 1'b1);
        cycle(10'h000, 1'b0);
        chk("relock_needs_full", 32'(locked), 32'd0);
        cycle(10'h354, 1'b1);
        cycle(10'h000, 1'b0);
        chk("relock_done", 32'(locked), 32'd1);

        // ---- decode table ----
        do_reset();
        for (int i = 0; i < 23; i++) begin
            cycle(vecs[i].sym, 1'b1);
            if (vecs[i].chk_vid) chk("tab_video", 32'(video_data), 32'(vecs[i].video));
            chk("tab_is_ctrl",  32'(is_ctrl),    32'(vecs[i].is_ctrl));
            chk("tab_ctrl",     32'(ctrl),       32'(vecs[i].ctrl));
            chk("tab_is_terc4", 32'(is_terc4),   32'(vecs[i].is_terc4));
            chk("tab_terc4",    32'(terc4_data), 32'(vecs[i].terc4));
        end

        // ---- randomized phases against the model ----
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) mode = $urandom_range(0, 2);
            if (i == 1500) do_reset();
            v  = ($urandom_range(0, 9) != 0);
            rv = $urandom;
            case (mode)
                0: s = (rv[31:25] < 7'd118) ? ctrl_tab[rv[11:10]] : rv[9:0];
                1: s = rv[9:0];
                default: begin
                    if (rv[31:30] == 2'd0)      s = ctrl_tab[rv[11:10]];
                    else if (rv[31:30] == 2'd1) s = terc_tab[rv[13:10]];
                    else                        s = rv[9:0];
                end
            endcase
            cycle(s, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
